// File: rtl/pi_1_unshuffle_gather_pkg.sv
// Shared definitions for the PE<->CNU shuffle pair: default dimensions, message type,
// gather FSM states and the PE column-major index helper.
package pi_1_unshuffle_gather_pkg;

    localparam int unsigned K_DEFAULT          = 6;
    localparam int unsigned DATA_WIDTH_DEFAULT = 6;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] msg_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gather_state_t;

    // Position of PE(x, y) in the column-major frame
    function automatic int unsigned pe_index(input int unsigned x, input int unsigned y,
                                             input int unsigned k = K_DEFAULT);
        return y * k + x;
    endfunction

    function automatic int unsigned col_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/pi_1_frame_buf.sv
// One K*K message bank written a CNU column at a time, with a full flag that marks a
// complete frame until the consumer clears it.
module pi_1_frame_buf
    import pi_1_unshuffle_gather_pkg::*;
#(
    parameter int unsigned K          = K_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [col_width(K)-1:0]        wr_col,
    input  logic [0:K-1][DATA_WIDTH-1:0]   wr_data,
    input  logic                           set_full,
    input  logic                           clear,
    output logic                           full,
    output logic [0:K*K-1][DATA_WIDTH-1:0] data
);

    localparam int unsigned CW = col_width(K);

    logic [0:K*K-1][DATA_WIDTH-1:0] bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q <= '0;
            full   <= 1'b0;
        end else begin
            // set wins over clear so a frame completing on a consume cycle is kept
            if (clear)
                full <= 1'b0;
            if (set_full)
                full <= 1'b1;
            if (wr_en) begin
                for (int unsigned x = 0; x < K; x++) begin
                    if (wr_col == CW'(x)) begin
                        for (int unsigned j = 0; j < K; j++)
                            bank_q[pe_index(x, j, K)] <= wr_data[j];
                    end
                end
            end
        end
    end

    assign data = bank_q;

endmodule

// File: rtl/pi_1_unshuffle_gather.sv
// Inverse PE->CNU shuffle: gathers K CNU beats into one K*K frame in PE column-major order.
// Define PI1_UNSHUFFLE_PINGPONG_EN for two frame buffers (one fills while the other is held).
module pi_1_unshuffle_gather
    import pi_1_unshuffle_gather_pkg::*;
#(
    parameter int unsigned K          = K_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sof,
    input  logic [0:K-1][DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [0:K*K-1][DATA_WIDTH-1:0] out_data,
    output logic                           err_frame
);

    localparam int unsigned   CW       = col_width(K);
    localparam logic [CW-1:0] LAST_COL = CW'(K - 1);

    gather_state_t state_q, state_d;
    logic [CW-1:0] c_q, c_d, wr_col;
    logic          accept, consume, sof_err, last_beat, err_q;

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign sof_err   = accept && in_sof && (c_q != '0);
    // A misplaced SOF restarts the frame: that beat becomes CNU 0
    assign wr_col    = sof_err ? '0 : c_q;
    assign last_beat = accept && (wr_col == LAST_COL);
    assign err_frame = err_q;

    always_comb begin
        c_d = c_q;
        if (accept)
            c_d = last_beat ? '0 : wr_col + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            err_q   <= sof_err;
        end
    end

`ifdef PI1_UNSHUFFLE_PINGPONG_EN
    logic [1:0]                           full;
    logic [0:1][0:K*K-1][DATA_WIDTH-1:0]  frame_data;
    logic                                 wr_sel_q, rd_sel_q;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        pi_1_frame_buf #(
            .K          (K),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_frame_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (accept && (wr_sel_q == 1'(b))),
            .wr_col   (wr_col),
            .wr_data  (in_data),
            .set_full (last_beat && (wr_sel_q == 1'(b))),
            .clear    (consume && (rd_sel_q == 1'(b))),
            .full     (full[b]),
            .data     (frame_data[b])
        );
    end

    assign out_valid = full[rd_sel_q];
    assign out_data  = frame_data[rd_sel_q];
    // HOLD means both banks are full, so wr_sel == rd_sel and a consume frees the write bank
    assign in_ready  = (state_q == FILL) || consume;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (last_beat && full[~wr_sel_q] && !consume) state_d = HOLD;
            HOLD: if (consume) state_d = (last_beat && full[~wr_sel_q]) ? HOLD : FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (last_beat)
                wr_sel_q <= ~wr_sel_q;
            if (consume)
                rd_sel_q <= ~rd_sel_q;
        end
    end
`else
    logic full;

    pi_1_frame_buf #(
        .K          (K),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_frame_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_col   (wr_col),
        .wr_data  (in_data),
        .set_full (last_beat),
        .clear    (consume),
        .full     (full),
        .data     (out_data)
    );

    assign out_valid = full;
    assign in_ready  = (state_q == FILL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (last_beat) state_d = HOLD;
            HOLD: if (consume)   state_d = FILL;
        endcase
    end
`endif

endmodule

// File: tb/tb_pi_1_unshuffle_gather.sv
// Self-checking bench for pi_1_unshuffle_gather; reference is the forward shuffle
// applied to random PE frames (expects the original frame back).
`timescale 1ns/1ps
module tb_pi_1_unshuffle_gather;
    import pi_1_unshuffle_gather_pkg::*;

    localparam int unsigned K  = 6;
    localparam int unsigned DW = 6;
    localparam int unsigned N  = K * K;
`ifdef PI1_UNSHUFFLE_PINGPONG_EN
    localparam int unsigned FRAME_PERIOD = K;
`else
    localparam int unsigned FRAME_PERIOD = K + 1;
`endif

    typedef logic [0:K-1][DW-1:0] beat_t;
    typedef logic [0:N-1][DW-1:0] frame_t;

    logic   clk = 1'b0;
    logic   rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, err_frame;
    beat_t  in_data;
    frame_t out_data;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned edge_cnt   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    pi_1_unshuffle_gather #(
        .K          (K),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_frame (err_frame)
    );

    // Forward shuffle: CNU c receives the message of PE(c, j) on lane j
    function automatic beat_t shuffle_beat(input frame_t v, input int unsigned c);
        beat_t b;
        for (int unsigned j = 0; j < K; j++)
            b[j] = v[pe_index(c, j, K)];
        return b;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int unsigned i = 0; i < N; i++)
            f[i] = DW'($urandom);
        return f;
    endfunction

    // Offer one beat and return one time step after the edge that takes it
    task automatic drive_beat(input beat_t d, input logic sof);
        int unsigned waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL drive_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input frame_t v, input logic first_sof);
        for (int unsigned c = 0; c < K; c++)
            drive_beat(shuffle_beat(v, c), (c == 0) ? first_sof : 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        compared++;
        if (err_frame !== 1'b0) begin mismatched++; $display("FAIL reset_err_frame: got %0b want 0", err_frame); end
        compared++;
        if (out_data !== '0) begin mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_order();
        beat_t  b;
        frame_t exp;
        out_ready = 1'b1;
        for (int unsigned c = 0; c < K; c++) begin
            for (int unsigned j = 0; j < K; j++) begin
                b[j] = DW'(c * K + j);
                exp[pe_index(c, j, K)] = b[j];
            end
            drive_beat(b, c == 0);
            if (c == K - 2) begin
                compared++;
                if (out_valid !== 1'b0) begin mismatched++; $display("FAIL order_early_valid: got %0b want 0", out_valid); end
            end
        end
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL order_valid: got %0b want 1", out_valid); end
        compared++;
        if (out_data[1] !== 6'd6) begin mismatched++; $display("FAIL order_idx1: got %0d want 6", out_data[1]); end
        compared++;
        if (out_data[6] !== 6'd1) begin mismatched++; $display("FAIL order_idx6: got %0d want 1", out_data[6]); end
        compared++;
        if (out_data[35] !== 6'd35) begin mismatched++; $display("FAIL order_idx35: got %0d want 35", out_data[35]); end
        compared++;
        if (out_data !== exp) begin mismatched++; $display("FAIL order_frame: got %h want %h", out_data, exp); end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL order_consumed: got %0b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_round_trip();
        frame_t      v;
        int unsigned dly;
        for (int unsigned n = 0; n < 3; n++) begin
            v = rand_frame();
            out_ready = 1'b0;
            send_frame(v, 1'b1);
            dly = $urandom_range(3, 0);
            for (int unsigned d = 0; d < dly; d++) begin
                @(posedge clk);
                #1;
            end
            compared++;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL round_trip_valid[%0d]: got %0b want 1", n, out_valid); end
            compared++;
            if (out_data !== v) begin mismatched++; $display("FAIL round_trip_data[%0d]: got %h want %h", n, out_data, v); end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("FAIL round_trip_drain[%0d]: got %0b want 0", n, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        frame_t f0, f1;
        f0 = rand_frame();
        f1 = rand_frame();
        out_ready = 1'b0;
        send_frame(f0, 1'b1);
        for (int unsigned i = 0; i < 10; i++) begin
            compared++;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
            compared++;
            if (out_data !== f0) begin mismatched++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data, f0); end
            compared++;
`ifdef PI1_UNSHUFFLE_PINGPONG_EN
            if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %0b want 1", i, in_ready); end
`else
            if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
`endif
            @(posedge clk);
            #1;
        end
`ifdef PI1_UNSHUFFLE_PINGPONG_EN
        send_frame(f1, 1'b1);
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_both_full: got %0b want 0", in_ready); end
        compared++;
        if (out_data !== f0) begin mismatched++; $display("FAIL bp_hold_first: got %h want %h", out_data, f0); end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_consume_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_second_valid: got %0b want 1", out_valid); end
        compared++;
        if (out_data !== f1) begin mismatched++; $display("FAIL bp_second_data: got %h want %h", out_data, f1); end
        @(posedge clk);
        #1;
`else
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
`endif
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %0b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_sof_err();
        frame_t v;
        v = rand_frame();
        v[0] = 6'h2A;
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            drive_beat(shuffle_beat(rand_frame(), c), c == 0);
            compared++;
            if (err_frame !== 1'b0) begin mismatched++; $display("FAIL sof_no_err[%0d]: got %0b want 0", c, err_frame); end
        end
        drive_beat(shuffle_beat(v, 0), 1'b1);
        compared++;
        if (err_frame !== 1'b1) begin mismatched++; $display("FAIL sof_err_pulse: got %0b want 1", err_frame); end
        for (int unsigned c = 1; c < K; c++) begin
            drive_beat(shuffle_beat(v, c), 1'b0);
            compared++;
            if (err_frame !== 1'b0) begin mismatched++; $display("FAIL sof_err_clear[%0d]: got %0b want 0", c, err_frame); end
        end
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL sof_valid: got %0b want 1", out_valid); end
        compared++;
        if (out_data[0] !== 6'h2A) begin mismatched++; $display("FAIL sof_idx0: got %h want 2a", out_data[0]); end
        compared++;
        if (out_data !== v) begin mismatched++; $display("FAIL sof_frame: got %h want %h", out_data, v); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        frame_t v;
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 5; c++)
            drive_beat(shuffle_beat(rand_frame(), c), c == 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
        compared++;
        if (err_frame !== 1'b0) begin mismatched++; $display("FAIL rstmid_err: got %0b want 0", err_frame); end
        compared++;
        if (out_data !== '0) begin mismatched++; $display("FAIL rstmid_cleared: got %h want 0", out_data); end
        v = rand_frame();
        for (int unsigned c = 0; c < K; c++) begin
            drive_beat(shuffle_beat(v, c), 1'b0);
            compared++;
            if (err_frame !== 1'b0) begin mismatched++; $display("FAIL rstmid_beat_err[%0d]: got %0b want 0", c, err_frame); end
        end
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_frame_valid: got %0b want 1", out_valid); end
        compared++;
        if (out_data !== v) begin mismatched++; $display("FAIL rstmid_frame: got %h want %h", out_data, v); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_throughput();
        frame_t      frames [5];
        int unsigned t_first = 0;
        int unsigned t_fifth = 0;
        int unsigned got     = 0;
        for (int unsigned f = 0; f < 5; f++)
            frames[f] = rand_frame();
        out_ready = 1'b1;
        fork
            begin
                for (int unsigned f = 0; f < 5; f++) begin
                    for (int unsigned c = 0; c < K; c++) begin
                        drive_beat(shuffle_beat(frames[f], c), c == 0);
                        if (c == 0 && f == 0) t_first = edge_cnt;
                        if (c == 0 && f == 4) t_fifth = edge_cnt;
                    end
                end
            end
            begin
                int unsigned cyc = 0;
                while (got < 5 && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        compared++;
                        if (out_data !== frames[got]) begin
                            mismatched++;
                            $display("FAIL tput_frame[%0d]: got %h want %h", got, out_data, frames[got]);
                        end
                        got++;
                    end
                end
            end
        join
        compared++;
        if (got != 5) begin mismatched++; $display("FAIL tput_frames_out: got %0d want 5", got); end
        compared++;
        if (t_fifth - t_first != 4 * FRAME_PERIOD) begin
            mismatched++;
            $display("FAIL tput_cycles: got %0d want %0d", t_fifth - t_first, 4 * FRAME_PERIOD);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_order();
        test_round_trip();
        test_backpressure();
        test_sof_err();
        test_reset_mid();
        test_throughput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
